// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg
//   Shared core definitions used by the decode stage and the immediate
//   extender: RV32 base opcodes, immediate-format select encodings and the
//   decoded-entry record that the decode stage buffers.
//   No ports (package).
package decode_stage_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Immediate-format select seen by the extender. IMM_IU is the 5-bit
  // zero-extended CSR immediate (uimm in rs1 position).
  localparam logic [2:0] IMM_I  = 3'b000;
  localparam logic [2:0] IMM_S  = 3'b001;
  localparam logic [2:0] IMM_B  = 3'b010;
  localparam logic [2:0] IMM_J  = 3'b011;
  localparam logic [2:0] IMM_U  = 3'b100;
  localparam logic [2:0] IMM_IU = 3'b101;

  typedef struct packed {
    logic [24:0] instr;    // instruction bits [31:7]
    logic [2:0]  immsrc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc;
    logic        illegal;
  } dec_entry_t;

  function automatic dec_entry_t pack_entry(
    input logic [31:0] instr,
    input logic [31:0] pc,
    input logic [2:0]  immsrc,
    input logic        illegal
  );
    dec_entry_t e;
    e.instr   = instr[31:7];
    e.immsrc  = immsrc;
    e.rd      = instr[11:7];
    e.rs1     = instr[19:15];
    e.rs2     = instr[24:20];
    e.pc      = pc;
    e.illegal = illegal;
    return e;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if
//   Fetch-side and downstream-side handshake/bus bundle of the decode stage.
//   slave  : decode stage view (accepts from fetch, presents to extender)
//   master : environment view (fetch driver + downstream consumer)
//   Signals: in_valid/in_ready/in_instr/in_pc, out_valid/out_ready,
//            out_instr/out_immsrc/out_rd/out_rs1/out_rs2/out_pc/out_illegal
interface decode_stage_if;
  import decode_stage_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;

  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_instr;
  logic [2:0]  out_immsrc;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [31:0] out_pc;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_immsrc,
           out_rd, out_rs1, out_rs2, out_pc, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_immsrc,
           out_rd, out_rs1, out_rs2, out_pc, out_illegal
  );

endinterface

// File: rtl/decode_stage_imm_decoder.sv
// imm_decoder
//   Combinational opcode classifier: picks the immediate format for the
//   extender and flags opcodes outside the supported set.
//   i_opcode  [6:0] : instruction bits [6:0]
//   o_immsrc  [2:0] : immediate-format select (IMM_I for unsupported opcodes)
//   o_illegal       : opcode not supported
module imm_decoder
  import decode_stage_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic [2:0] o_immsrc,
  output logic       o_illegal
);

  always_comb begin
    o_immsrc  = IMM_I;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_REG: o_immsrc = IMM_I;
      OP_STORE:                         o_immsrc = IMM_S;
      OP_BRANCH:                        o_immsrc = IMM_B;
      OP_JAL:                           o_immsrc = IMM_J;
      OP_LUI, OP_AUIPC:                 o_immsrc = IMM_U;
      OP_SYSTEM:                        o_immsrc = IMM_IU;
      default:                          o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage
//   Decode pipeline stage with a 2-entry skid buffer. Instructions are
//   decoded as they are captured, so both buffer entries hold decoded
//   fields. in_ready comes straight from the state register, which breaks
//   the combinational path from out_ready back to fetch.
//   clk   : rising-edge clock
//   rstn  : synchronous active-low reset
//   flush : drop every buffered instruction and any same-cycle input
//   bus   : decode_stage_if.slave (fetch handshake in, decoded fields out)
//
//   state   | meaning
//   EMPTY   | nothing buffered, out_valid=0
//   ONE     | OUT holds the presented instruction, SKID free
//   TWO     | OUT presented, SKID holds the next one, in_ready=0
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic           clk,
  input  logic           rstn,
  input  logic           flush,
  decode_stage_if.slave  bus
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0] r_state;
  dec_entry_t r_out;
  dec_entry_t r_skid;

  logic [2:0] w_immsrc;
  logic       w_illegal;
  dec_entry_t w_dec;
  logic       w_in_xfer;
  logic       w_out_xfer;

  imm_decoder u_imm_decoder (
    .i_opcode  (bus.in_instr[6:0]),
    .o_immsrc  (w_immsrc),
    .o_illegal (w_illegal)
  );

  assign w_dec = pack_entry(bus.in_instr, bus.in_pc, w_immsrc, w_illegal);

  assign bus.in_ready  = (r_state != S_TWO);
  assign bus.out_valid = (r_state != S_EMPTY);

  assign w_in_xfer  = bus.in_valid  & bus.in_ready;
  assign w_out_xfer = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_EMPTY;
      r_out   <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            r_out   <= w_dec;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_out <= w_dec;
          end else if (w_in_xfer) begin
            r_skid  <= w_dec;
            r_state <= S_TWO;
          end else if (w_out_xfer) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_out_xfer) begin
            r_out   <= r_skid;
            r_state <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign bus.out_instr  = r_out.instr;
  assign bus.out_immsrc = r_out.immsrc;
  assign bus.out_rd     = r_out.rd;
  assign bus.out_rs1    = r_out.rs1;
  assign bus.out_rs2    = r_out.rs2;
  assign bus.out_pc     = r_out.pc;
  // OUT keeps stale contents after draining or a flush; mask the flag so an
  // empty stage never reports an illegal instruction.
  assign bus.out_illegal = r_out.illegal & bus.out_valid;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Self-checking bench for decode_stage. A FIFO-of-depth-2 reference model
//   tracks which decoded instructions must be visible; a negedge process
//   compares the DUT against it every cycle, and directed scenarios pin
//   hand-computed literal values.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic clk;
  logic rstn;
  logic flush;

  decode_stage_if bus();

  decode_stage dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  dec_entry_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode written from the opcode table directly.
  function automatic dec_entry_t mdl_decode(input logic [31:0] w, input logic [31:0] pc);
    dec_entry_t e;
    e.instr   = w[31:7];
    e.rd      = w[11:7];
    e.rs1     = w[19:15];
    e.rs2     = w[24:20];
    e.pc      = pc;
    e.illegal = 1'b0;
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h33: e.immsrc = 3'd0;
      7'h23:                      e.immsrc = 3'd1;
      7'h63:                      e.immsrc = 3'd2;
      7'h6F:                      e.immsrc = 3'd3;
      7'h37, 7'h17:               e.immsrc = 3'd4;
      7'h73:                      e.immsrc = 3'd5;
      default: begin
        e.immsrc  = 3'd0;
        e.illegal = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Model: the stage behaves as an in-order queue holding at most two items.
  always @(posedge clk) begin
    bit in_x, out_x;
    if (!rstn || flush) begin
      q.delete();
    end else begin
      in_x  = bus.in_valid && (q.size() < 2);
      out_x = (q.size() > 0) && bus.out_ready;
      if (out_x) begin
        void'(q.pop_front());
        n_out++;
      end
      if (in_x) q.push_back(mdl_decode(bus.in_instr, bus.in_pc));
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      check("in_ready", {31'b0, bus.in_ready}, {31'b0, q.size() < 2});
      check("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() > 0});
      if (q.size() > 0) begin
        check("out_instr",   {7'b0, bus.out_instr},    {7'b0, q[0].instr});
        check("out_immsrc",  {29'b0, bus.out_immsrc},  {29'b0, q[0].immsrc});
        check("out_rd",      {27'b0, bus.out_rd},      {27'b0, q[0].rd});
        check("out_rs1",     {27'b0, bus.out_rs1},     {27'b0, q[0].rs1});
        check("out_rs2",     {27'b0, bus.out_rs2},     {27'b0, q[0].rs2});
        check("out_pc",      bus.out_pc,               q[0].pc);
        check("out_illegal", {31'b0, bus.out_illegal}, {31'b0, q[0].illegal});
      end else begin
        check("idle_illegal", {31'b0, bus.out_illegal}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_instr = w;
    bus.in_pc    = pc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"},   {31'b0, bus.out_valid},   32'd0);
    check({tag, "_in_ready"},    {31'b0, bus.in_ready},    32'd1);
    check({tag, "_out_illegal"}, {31'b0, bus.out_illegal}, 32'd0);
    check({tag, "_out_immsrc"},  {29'b0, bus.out_immsrc},  32'd0);
    check({tag, "_out_instr"},   {7'b0, bus.out_instr},    32'd0);
    check({tag, "_out_rd"},      {27'b0, bus.out_rd},      32'd0);
    check({tag, "_out_rs1"},     {27'b0, bus.out_rs1},     32'd0);
    check({tag, "_out_rs2"},     {27'b0, bus.out_rs2},     32'd0);
    check({tag, "_out_pc"},      bus.out_pc,               32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  ops [10];
    logic [39:0] pat_in;
    logic [39:0] pat_out;
    int          bubbles;
    int          out_base;

    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h33};

    rstn  = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);

    // Reset state
    step();
    step();
    check_reset_outputs("reset");
    rstn = 1'b1;
    step();

    // Basic flow: addi x1, x0, 5
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h00500093, 32'h100);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("basic_out_valid", {31'b0, bus.out_valid}, 32'd1);
    check("basic_immsrc", {29'b0, bus.out_immsrc}, 32'd0);
    check("basic_rd", {27'b0, bus.out_rd}, 32'd1);
    check("basic_pc", bus.out_pc, 32'h100);
    step();
    check("basic_drained", {31'b0, bus.out_valid}, 32'd0);

    // Backpressure: sw then beq with out_ready low
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00112023, 32'h200);
    step();
    drive(1'b1, 32'h00208463, 32'h204);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("bp_pc0", bus.out_pc, 32'h200);
    check("bp_immsrc0", {29'b0, bus.out_immsrc}, 32'd1);
    step();
    check("bp_hold_pc", bus.out_pc, 32'h200);
    bus.out_ready = 1'b1;
    step();
    check("bp_pc1", bus.out_pc, 32'h204);
    check("bp_immsrc1", {29'b0, bus.out_immsrc}, 32'd2);
    check("bp_in_ready_one", {31'b0, bus.in_ready}, 32'd1);
    step();
    check("bp_drained", {31'b0, bus.out_valid}, 32'd0);

    // Flush in TWO with a same-cycle input
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00A00113, 32'h300);
    step();
    drive(1'b1, 32'h00B00193, 32'h304);
    step();
    check("fl_two", {31'b0, bus.in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'h00C00213, 32'h308);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("fl_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("fl_in_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    repeat (3) step();
    check("fl_nothing_emitted", {31'b0, bus.out_valid}, 32'd0);

    // Flush in ONE with a same-cycle accepted input
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00D00293, 32'h400);
    step();
    flush = 1'b1;
    drive(1'b1, 32'h00E00313, 32'h404);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("fl1_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("fl1_in_ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    check("fl1_still_empty", {31'b0, bus.out_valid}, 32'd0);

    // Opcode sweep, back to back
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h0080006F, 32'h500);
    step();
    check("sw_jal", {29'b0, bus.out_immsrc}, 32'd3);
    drive(1'b1, 32'h123450B7, 32'h504);
    step();
    check("sw_lui", {29'b0, bus.out_immsrc}, 32'd4);
    check("sw_lui_rd", {27'b0, bus.out_rd}, 32'd1);
    drive(1'b1, 32'h30001073, 32'h508);
    step();
    check("sw_csrrw", {29'b0, bus.out_immsrc}, 32'd5);
    check("sw_csrrw_ill", {31'b0, bus.out_illegal}, 32'd0);
    drive(1'b1, 32'h0000007F, 32'h50C);
    step();
    check("sw_bad_ill", {31'b0, bus.out_illegal}, 32'd1);
    check("sw_bad_immsrc", {29'b0, bus.out_immsrc}, 32'd0);
    check("sw_bad_pc", bus.out_pc, 32'h50C);
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("sw_ill_cleared", {31'b0, bus.out_illegal}, 32'd0);

    // Throughput: 100 back-to-back instructions
    bubbles  = 0;
    out_base = n_out;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, {7'(i), 5'(i + 1), 5'(i + 2), 3'(i), 5'(i + 3), ops[i % 10]},
            32'h1000 + 32'(4 * i));
      step();
      if (!bus.out_valid || bus.out_pc !== 32'h1000 + 32'(4 * i)) bubbles++;
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("tp_bubbles", 32'(bubbles), 32'd0);
    check("tp_count", 32'(n_out - out_base), 32'd100);

    // Mixed handshake patterns
    pat_in  = 40'hB6_D53A_9FC1;
    pat_out = 40'h5E_39A6_C74B;
    for (int i = 0; i < 40; i++) begin
      bus.out_ready = pat_out[i];
      drive(pat_in[i], {ops[(i * 3) % 10] == 7'h33 ? 25'h0ABCDE : 25'(i * 7919), ops[(i * 3) % 10]},
            32'h2000 + 32'(4 * i));
      step();
    end
    drive(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    repeat (3) step();
    check("mix_drained", {31'b0, bus.out_valid}, 32'd0);

    // Reset mid-stream while TWO
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00112023, 32'h600);
    step();
    drive(1'b1, 32'h0000007F, 32'h604);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("mr_two", {31'b0, bus.in_ready}, 32'd0);
    rstn = 1'b0;
    step();
    check_reset_outputs("midreset");
    rstn = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) step();
    check("mr_stays_empty", {31'b0, bus.out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock for the block; all state changes on rising edge.
REQ-002 SHALL have port rstn, input, 1, reset that is synchronous and active-low.
REQ-003 SHALL have port flush, input, 1, discards all buffered instructions (branch mispredict/redirect).
REQ-004 SHALL have port in_valid, input, 1, fetch presents an instruction.
REQ-005 SHALL have port in_ready, output, 1, stage can accept an instruction this cycle.
REQ-006 SHALL have port in_instr, input, 32, fetched instruction word.
REQ-007 SHALL have port in_pc, input, 32, PC of in_instr.
REQ-008 SHALL have port out_valid, output, 1, decoded instruction available.
REQ-009 SHALL have port out_ready, input, 1, downstream (extend/execute) consumes this cycle.
REQ-010 SHALL have port out_instr, output, 25, instruction bits [31:7] for the immediate extender.
REQ-011 SHALL have port out_immsrc, output, 3, immediate-format select for the extender.
REQ-012 SHALL have port out_rd / out_rs1 / out_rs2, output, 5 each, register fields.
REQ-013 SHALL have port out_pc, output, 32, PC of the presented instruction.
REQ-014 SHALL have port out_illegal, output, 1, opcode not in the supported set.

Function
REQ-015 SHALL transfer on input when in_valid & in_ready, and on output when out_valid & out_ready.
REQ-016 SHALL hold a 2-entry buffer: output register (OUT) plus skid register (SKID); states EMPTY, ONE, TWO.
REQ-017 SHALL drive in_ready = (state != TWO), from a register only, with no combinational path from out_ready.
REQ-018 SHALL decode at capture time; stored entries hold the decoded fields, not only the raw word.
REQ-019 SHALL map the opcode to immsrc: 0000011/0010011/1100111 -> 000; 0100011 -> 001; 1100011 -> 010; 1101111 -> 011; 0110111/0010111 -> 100; 1110011 -> 101; 0110011 -> 000.
REQ-020 SHALL set out_illegal=1 and immsrc=000 for any other opcode, and pass the instruction downstream unchanged otherwise.
REQ-021 SHALL implement the EMPTY state: on input transfer -> ONE, with the input in OUT.
REQ-022 SHALL implement the ONE state with these cases:
  - input only -> TWO, input into SKID.
  - output only -> EMPTY.
  - both -> ONE, input into OUT.
  - neither -> hold.
REQ-023 SHALL implement the TWO state: on output transfer -> ONE, with SKID moved to OUT; no input accepted in TWO.
REQ-024 SHALL latency 1 cycle: an instruction accepted at edge N SHALL be presented at out_* after edge N when the stage was EMPTY.
REQ-025 SHALL preserve order; an instruction is never duplicated or dropped unless flushed.
REQ-026 SHALL hold all out_* stable while out_valid & !out_ready.
REQ-027 SHALL, on flush, go to EMPTY at the next edge regardless of in_valid/out_ready; a same-cycle input transfer SHALL be discarded.
REQ-028 SHALL keep in_ready=1 in the cycle after a flush.
REQ-029 SHALL treat out_* as don't-care when out_valid=0, except out_illegal, which SHALL be 0.

Reset
REQ-030 SHALL, on rstn=0 at a clock edge, enter state EMPTY.
REQ-031 SHALL, on reset, drive out_valid=0, in_ready=1, out_illegal=0, out_immsrc=000, and zero all other out_*.
REQ-032 SHALL take priority of reset over flush and transfers; reset mid-stream drops both entries.

Structure
REQ-033 SHALL place the opcode constants and the immsrc encodings (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_IU) in a shared core package, used by both this block and the extender.
REQ-034 SHALL place the decoded-entry struct type (instr[31:7], immsrc, rd, rs1, rs2, pc, illegal) in the same package.
REQ-035 SHALL use one combinational sub-module, imm_decoder (instr -> immsrc, illegal), instantiated once at the input side.

Verification
REQ-036 SHALL cover basic flow:
  - stimulus: reset, then in_instr=0x00500093 (addi), pc=0x100, out_ready=1.
  - response: after 1 cycle out_valid=1, immsrc=000, rd=1, pc=0x100.
REQ-037 SHALL cover backpressure:
  - stimulus: out_ready=0; feed sw 0x00112023, then beq 0x00208463.
  - response: state TWO, in_ready=0; after release, outputs in order with immsrc 001 then 010.
REQ-038 SHALL cover flush:
  - stimulus: flush in TWO, with in_valid=1 in the same cycle.
  - response: next cycle out_valid=0, in_ready=1; the flushed and the same-cycle input are never emitted.
REQ-039 SHALL cover the opcode sweep:
  - stimulus: jal 0x0080006F, lui 0x123450B7, csrrw 0x30001073, opcode 0x0000007F.
  - response: immsrc 011, 100, 101, then out_illegal=1.
REQ-040 SHALL cover throughput:
  - stimulus: continuous in_valid and out_ready=1 for 100 instructions.
  - response: one output per cycle, no bubbles, with a scoreboard order match.
REQ-041 SHALL cover reset mid-stream:
  - stimulus: rstn=0 while in TWO.
  - response: next cycle out_valid=0, in_ready=1, all outputs zero.
